// File: rtl/fetch_unit.sv
// PC register plus fetch buffer feeding decode through a valid/ready handshake.
// Memory is combinational: the word for instr_addr is captured in the same cycle.
module fetch_unit #(
    parameter int              ADDR_WIDTH = 32,
    parameter int              DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h00000000,
    parameter int              DEPTH      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [ADDR_WIDTH-1:0]      instr_addr,
    input  logic [DATA_WIDTH-1:0]      instr,
    input  logic                       redirect_valid,
    input  logic [ADDR_WIDTH-1:0]      redirect_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_instr,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h00000013);

    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  pop_s;
    logic                  push_s;

    // Handshake decode; a full buffer may still accept when the head leaves.
    always_comb begin
        pop_s  = (count_r != CNT_W'(0)) & out_ready;
        push_s = ~redirect_valid & ((count_r < CNT_W'(DEPTH)) | pop_s);
    end

    // PC, buffer storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r     <= RESET_PC;
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]    <= ADDR_WIDTH'(0);
                instr_mem_r[i] <= NOP_INSTR;
            end
        end else if (redirect_valid) begin
            // Low address bits are dropped so the PC stays word aligned.
            pc_r     <= redirect_target & ~ADDR_WIDTH'(3);
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]    <= pc_r;
                instr_mem_r[wr_ptr_r] <= instr;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
                pc_r                  <= pc_r + ADDR_WIDTH'(4);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Present the head entry, or a NOP at PC 0 when nothing is buffered.
    always_comb begin
        out_valid = (count_r != CNT_W'(0));
        if (out_valid) begin
            out_instr = instr_mem_r[rd_ptr_r];
            out_pc    = pc_mem_r[rd_ptr_r];
        end else begin
            out_instr = NOP_INSTR;
            out_pc    = ADDR_WIDTH'(0);
        end
    end

    assign instr_addr = pc_r;
    assign buf_count  = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference queue of fetched entries plus
// directed checks on the externally visible sequence.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  buf_count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_pc;
    bit          model_valid = 1'b0;

    fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h00000000),
        .DEPTH      (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_addr      (instr_addr),
        .instr           (instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .buf_count       (buf_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00300093;
            32'h4:   return 32'h00200113;
            32'h8:   return 32'h002081b3;
            32'hC:   return 32'h00000013;
            default: return a ^ 32'h5A5A0F0F;
        endcase
    endfunction

    assign instr = mem_word(instr_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle: compare outputs against the model, advance the model, move to next negedge.
    task automatic step(input bit rst, input bit rdr, input logic [31:0] tgt, input bit rdy);
        bit pop, push;
        reset           = rst;
        redirect_valid  = rdr;
        redirect_target = tgt;
        out_ready       = rdy;
        if (model_valid) begin
            check_eq("sb_valid", out_valid, exp_q.size() != 0);
            check_eq("sb_count", buf_count, exp_q.size());
            check_eq("sb_addr", instr_addr, model_pc);
            if (exp_q.size() != 0) begin
                check_eq("sb_head", {out_pc, out_instr}, exp_q[0]);
            end else begin
                check_eq("sb_empty", {out_pc, out_instr}, {32'h0, 32'h00000013});
            end
        end
        if (rst) begin
            exp_q.delete();
            model_pc    = 32'h0;
            model_valid = 1'b1;
        end else if (rdr) begin
            exp_q.delete();
            model_pc = {tgt[31:2], 2'b00};
        end else begin
            pop  = (exp_q.size() != 0) && rdy;
            push = (exp_q.size() < DEPTH) || pop;
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                exp_q.push_back({model_pc, mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; out_ready = 1'b0;

        // Reset then stream
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_count", buf_count, 2'd0);
        check_eq("rst_instr", out_instr, 32'h00000013);
        check_eq("rst_pc", out_pc, 32'h0);
        check_eq("rst_addr", instr_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("s0", {out_valid, out_pc, out_instr}, {1'b1, 32'h0, 32'h00300093});
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("s1", {out_valid, out_pc, out_instr}, {1'b1, 32'h4, 32'h00200113});
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("s2", {out_valid, out_pc, out_instr}, {1'b1, 32'h8, 32'h002081b3});
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("s3", {out_valid, out_pc, out_instr}, {1'b1, 32'hC, 32'h00000013});

        // Back-pressure from reset release
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("bp_cnt1", buf_count, 2'd1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("bp_cnt2", buf_count, 2'd2);
        check_eq("bp_addr", instr_addr, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("bp_hold", {buf_count, instr_addr, out_pc}, {2'd2, 32'h8, 32'h0});

        // Full buffer with pop: count stays, PC advances
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("fp_state", {buf_count, instr_addr, out_pc}, {2'd2, 32'hC, 32'h4});
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("fp_next", out_pc, 32'h8);

        // Redirect with full buffer
        step(1'b0, 1'b1, 32'h4, 1'b1);
        check_eq("rd_flush", {buf_count, out_valid, instr_addr}, {2'd0, 1'b0, 32'h4});
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("rd_first", {out_pc, out_instr}, {32'h4, 32'h00200113});

        // Misaligned target, back-to-back redirect, PC wrap
        step(1'b0, 1'b1, 32'h0000000B, 1'b1);
        check_eq("mis_addr", instr_addr, 32'h8);
        step(1'b0, 1'b1, 32'hFFFFFFFC, 1'b1);
        check_eq("b2b_addr", instr_addr, 32'hFFFFFFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap_pc0", out_pc, 32'hFFFFFFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("wrap_pc1", out_pc, 32'h0);

        // Reset beats a simultaneous redirect
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("pre_rst_cnt", buf_count, 2'd2);
        step(1'b1, 1'b1, 32'h40, 1'b0);
        check_eq("mid_rst", {buf_count, out_valid, out_instr, out_pc, instr_addr},
                 {2'd0, 1'b0, 32'h00000013, 32'h0, 32'h0});

        // Random traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 64));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0, tgt,
                 $urandom_range(0, 2) != 0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
